// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: state encodings, default byte
// width and the rotate-priority search used by round-robin pickers.
package uart_pkg;

    localparam int DATA_W_DEFAULT = 8;

    localparam int ST_W = 1;
    localparam logic [ST_W-1:0] ST_IDLE = 1'b0;
    localparam logic [ST_W-1:0] ST_XFER = 1'b1;

    // Widest requester vector the search supports; narrower users zero-extend.
    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;
    localparam int PICK_W    = MAX_IDX_W + 1;

    // Returns {found, index} of the first set bit at ptr+1, ptr+2, ... modulo n.
    function automatic logic [PICK_W-1:0] rr_search(
        input logic [MAX_REQ-1:0] valid,
        input int unsigned        ptr,
        input int unsigned        n
    );
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
        int unsigned          j;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            j = (ptr + k) % n;
            if (!found && (k <= n) && valid[j[MAX_IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = j[MAX_IDX_W-1:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side valid/ready handshakes of the UART arbiter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEFAULT
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_valid;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_ready;

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data
    );

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after ptr, wrapping around.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       any,
    output logic [$clog2(NUM_REQ)-1:0] idx
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [MAX_REQ-1:0] valid_ext;
    logic [PICK_W-1:0]  result;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = req_valid;
        result                   = rr_search(valid_ext, 32'(ptr), NUM_REQ);
        any                      = result[PICK_W-1];
        idx                      = IDX_W'(result[MAX_IDX_W-1:0]);
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte streams: round-robin grant that
// stays locked for a whole packet, revoked if the owner goes quiet for too long.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = DATA_W_DEFAULT,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_tx_arbiter_if.slave           bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_REQ - 1);

    logic [ST_W-1:0]    state;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   idle_cnt;
    logic               tx_valid_q;
    logic [DATA_W-1:0]  tx_data_q;
    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic               own_valid;
    logic               own_last;
    logic [DATA_W-1:0]  own_data;
    logic               accept;
    logic [NUM_REQ-1:0] ready_vec;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_valid (bus.req_valid),
        .ptr       (ptr),
        .any       (pick_any),
        .idx       (pick_idx)
    );

    // Only the owner can be accepted, and only when the output register can take a byte.
    always_comb begin
        own_valid           = bus.req_valid[grant_id];
        own_last            = bus.req_last[grant_id];
        own_data            = bus.req_data[grant_id*DATA_W +: DATA_W];
        accept              = (state == ST_XFER) && own_valid && (!tx_valid_q || bus.tx_ready);
        ready_vec           = '0;
        ready_vec[grant_id] = accept;
    end

    assign bus.req_ready = ready_vec;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else if (accept) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= own_data;
        end else if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
        end
    end

    // The packet lock is released by a last byte or by the idle timer; the pending
    // output byte is left to drain on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= PTR_RESET;
            grant_id <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            idle_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    idle_cnt <= '0;
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        busy     <= 1'b1;
                        state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (accept) begin
                        idle_cnt <= '0;
                        if (own_last) begin
                            state <= ST_IDLE;
                            ptr   <= grant_id;
                            busy  <= 1'b0;
                        end
                    end else if (!own_valid) begin
                        if (idle_cnt >= CNT_LIMIT) begin
                            timeout  <= 1'b1;
                            state    <= ST_IDLE;
                            ptr      <= grant_id;
                            busy     <= 1'b0;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: packet-level round-robin model feeding a
// byte scoreboard, plus directed reset, stall, timeout and mid-packet reset cases.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NREQ   = 4;
    localparam int DW     = 8;
    localparam int TMO    = 16;
    localparam int MAXLEN = 16;
    localparam int BUDGET = 600;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (NREQ),
        .DATA_W       (DW),
        .IDLE_TIMEOUT (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int timeout_seen = 0;

    // Per-requester byte streams, entries are {last, data}.
    logic [DW:0]   src_mem [NREQ][MAXLEN];
    int            src_len [NREQ];
    int            src_pos [NREQ];
    logic [DW-1:0] exp_q[$];
    int            model_ptr;
    int            ready_mode;
    int            stall_from;
    int            cyc;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < NREQ; i++)
            if (src_pos[i] < src_len[i]) p = 1'b1;
        return p;
    endfunction

    task automatic driveInputs();
        for (int i = 0; i < NREQ; i++) begin
            if (src_pos[i] < src_len[i]) begin
                bus.req_valid[i]         = 1'b1;
                bus.req_data[i*DW +: DW] = src_mem[i][src_pos[i]][DW-1:0];
                bus.req_last[i]          = src_mem[i][src_pos[i]][DW];
            end else begin
                bus.req_valid[i]         = 1'b0;
                bus.req_data[i*DW +: DW] = DW'($urandom);
                bus.req_last[i]          = 1'($urandom);
            end
        end
        case (ready_mode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = ($urandom_range(0, 9) < 7);
            default: bus.tx_ready = !((cyc >= stall_from) && (cyc < stall_from + 10));
        endcase
    endtask

    // One clock: note requester handshakes before the edge, drive new inputs after it.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++)
            if (bus.req_valid[i] && bus.req_ready[i]) src_pos[i]++;
        @(posedge clk);
        #1;
        cyc++;
        driveInputs();
    endtask

    task automatic loadPacket(input int id, input int len, input int base, input bit end_last);
        logic [DW-1:0] b;
        for (int k = 0; k < len; k++) begin
            b = (base >= 0) ? DW'(base + k) : {2'(id), 6'($urandom)};
            src_mem[id][k] = {(end_last && (k == len - 1)), b};
        end
        src_len[id] = len;
        src_pos[id] = 0;
    endtask

    // Packets that start together leave in rotation order after the last owner.
    task automatic commitRound(input logic [NREQ-1:0] mask);
        int last_id;
        int i;
        last_id = model_ptr;
        for (int k = 1; k <= NREQ; k++) begin
            i = (model_ptr + k) % NREQ;
            if (mask[i]) begin
                for (int b = 0; b < src_len[i]; b++) exp_q.push_back(src_mem[i][b][DW-1:0]);
                last_id = i;
            end
        end
        model_ptr = last_id;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] mask, input int len, input int base);
        for (int i = 0; i < NREQ; i++)
            if (mask[i]) loadPacket(i, (len > 0) ? len : int'($urandom_range(1, 6)), base, 1'b1);
        commitRound(mask);
        driveInputs();
    endtask

    task automatic runUntilDone(input string name);
        int n = 0;
        while ((pending() || exp_q.size() != 0) && n < BUDGET) begin
            step();
            n++;
        end
        checkOutput({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        if (pending() || exp_q.size() != 0) begin
            for (int i = 0; i < NREQ; i++) src_len[i] = 0;
            exp_q.delete();
            driveInputs();
        end
    endtask

    // Scoreboard and handshake-rule monitor, independent of the stimulus flow.
    initial begin
        logic          have_prev;
        logic          prev_last;
        logic [DW-1:0] prev_byte;
        logic          hold_prev;
        logic [DW-1:0] hold_byte;
        have_prev = 1'b0;
        prev_last = 1'b0;
        prev_byte = '0;
        hold_prev = 1'b0;
        hold_byte = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_prev = 1'b0;
                prev_last = 1'b0;
                hold_prev = 1'b0;
            end else begin
                if (have_prev) begin
                    checkOutput("accept_latency_valid", 32'(bus.tx_valid), 32'd1);
                    checkOutput("accept_latency_data", 32'(bus.tx_data), 32'(prev_byte));
                end
                if (prev_last) checkOutput("busy_after_last", 32'(busy), 32'd0);
                if (hold_prev) checkOutput("stall_hold", 32'({bus.tx_valid, bus.tx_data}), 32'({1'b1, hold_byte}));
                checkOutput("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
                if (bus.req_ready != '0) begin
                    checkOutput("ready_in_stall", 32'(!bus.tx_valid || bus.tx_ready), 32'd1);
                    checkOutput("ready_needs_busy", 32'(busy), 32'd1);
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("[TB] FAIL unexpected_byte: got 0x%0h, expected none", bus.tx_data);
                    end else begin
                        checkOutput("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                    end
                end
                if (timeout) timeout_seen++;
                have_prev = 1'b0;
                prev_last = 1'b0;
                for (int i = 0; i < NREQ; i++) begin
                    if (bus.req_valid[i] && bus.req_ready[i]) begin
                        have_prev = 1'b1;
                        prev_byte = bus.req_data[i*DW +: DW];
                        prev_last = bus.req_last[i];
                    end
                end
                hold_prev = bus.tx_valid && !bus.tx_ready;
                hold_byte = bus.tx_data;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst        = 1'b1;
        ready_mode = 0;
        stall_from = 0;
        cyc        = 0;
        model_ptr  = NREQ - 1;
        for (int i = 0; i < NREQ; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end

        // All four requesters wait through reset.
        applyStimulus(4'b1111, 2, -1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
            checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd0);
            checkOutput("reset_busy", 32'(busy), 32'd0);
        end
        rst = 1'b0;
        step();
        checkOutput("first_grant_busy", 32'(busy), 32'd1);
        checkOutput("first_grant_id", 32'(grant_id), 32'd0);
        runUntilDone("reset_round");

        // Contention twice: rotation restarts after requester 3.
        applyStimulus(4'b1011, 2, -1);
        runUntilDone("contention_a");
        applyStimulus(4'b1011, 2, -1);
        runUntilDone("contention_b");

        applyStimulus(4'b0100, 3, 'h41);
        runUntilDone("single_req2");

        // Ten-cycle output stall in the middle of a packet.
        ready_mode = 2;
        stall_from = cyc + 3;
        applyStimulus(4'b0011, 5, -1);
        runUntilDone("output_stall");
        ready_mode = 0;

        // Owner 1 goes quiet after one byte while requester 3 waits.
        loadPacket(1, 1, -1, 1'b0);
        exp_q.push_back(src_mem[1][0][DW-1:0]);
        driveInputs();
        n = 0;
        while (src_pos[1] < 1 && n < 50) begin
            step();
            n++;
        end
        checkOutput("timeout_first_accept", 32'(src_pos[1]), 32'd1);
        loadPacket(3, 2, -1, 1'b1);
        exp_q.push_back(src_mem[3][0][DW-1:0]);
        exp_q.push_back(src_mem[3][1][DW-1:0]);
        driveInputs();
        for (int k = 1; k <= TMO; k++) begin
            step();
            checkOutput("timeout_pulse", 32'(timeout), 32'(k == TMO));
            checkOutput("timeout_busy", 32'(busy), 32'(k != TMO));
        end
        step();
        checkOutput("timeout_regrant_busy", 32'(busy), 32'd1);
        checkOutput("timeout_regrant_id", 32'(grant_id), 32'd3);
        checkOutput("timeout_one_cycle", 32'(timeout), 32'd0);
        model_ptr = 3;
        runUntilDone("timeout_req3");

        // Reset while a byte is pending; everything in flight is dropped.
        applyStimulus(4'b0001, 6, -1);
        n = 0;
        while (!bus.tx_valid && n < 50) begin
            step();
            n++;
        end
        checkOutput("midreset_pending", 32'(bus.tx_valid), 32'd1);
        rst = 1'b1;
        step();
        checkOutput("midreset_tx_valid", 32'(bus.tx_valid), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        for (int i = 0; i < NREQ; i++) src_len[i] = 0;
        exp_q.delete();
        model_ptr = NREQ - 1;
        driveInputs();
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            checkOutput("post_reset_quiet", 32'(bus.tx_valid), 32'd0);
        end

        // Random rounds with random backpressure.
        ready_mode = 1;
        for (int r = 0; r < 25; r++) begin
            applyStimulus(4'($urandom_range(1, 15)), 0, -1);
            runUntilDone("random_round");
        end

        checkOutput("timeout_count", 32'(timeout_seen), 32'd1);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
